// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter sharing one FIFO write port among NUM_REQ producers.
// Optional beat/stall statistics counters are enabled with `define FIFO_WR_ARB_STATS_EN.
`timescale 1ns/1ps

module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_wr_data,
    input  logic                          fifo_wr_ready,
    output logic                          grant_valid,
`ifdef FIFO_WR_ARB_STATS_EN
    output logic [15:0]                   beat_count,
    output logic [15:0]                   stall_count,
`endif
    output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

    localparam int ID_W = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t          state;
    logic [ID_W-1:0] owner;
    logic [ID_W-1:0] rr_ptr;
    logic [7:0]      burst_cnt;

    logic [ID_W-1:0] winner;
    logic            any_valid;
    logic            sel_valid;
    logic [ID_W-1:0] sel_id;
    logic            stall;
    logic [7:0]      burst_next;

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        if (id == ID_W'(NUM_REQ - 1)) begin
            return '0;
        end
        return id + ID_W'(1);
    endfunction

    // First valid requester at or after rr_ptr, wrapping at NUM_REQ (not at 2**ID_W).
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        logic [ID_W:0] sum;
        winner    = '0;
        any_valid = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (ID_W + 1)'(k);
            if (sum >= (ID_W + 1)'(NUM_REQ)) begin
                sum = sum - (ID_W + 1)'(NUM_REQ);
            end
            if (!any_valid && req_valid[sum[ID_W-1:0]]) begin
                any_valid = 1'b1;
                winner    = sum[ID_W-1:0];
            end
        end
    end

    // Outputs are forced low while rst_n is asserted, even if producers keep requesting.
    always_comb begin
        sel_valid = 1'b0;
        sel_id    = '0;
        if (state == IDLE) begin
            sel_valid = any_valid;
            sel_id    = winner;
        end else begin
            sel_valid = req_valid[owner];
            sel_id    = owner;
        end
        grant_valid = rst_n && sel_valid;
        grant_id    = grant_valid ? sel_id : '0;
    end

    always_comb begin
        fifo_wr_data = '0;
        req_ready    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_id == ID_W'(i)) begin
                fifo_wr_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
            req_ready[i] = grant_valid && (grant_id == ID_W'(i)) && fifo_wr_ready;
        end
        fifo_wr_en = grant_valid && req_valid[grant_id] && fifo_wr_ready;
        stall      = grant_valid && req_valid[grant_id] && !fifo_wr_ready;
        burst_next = burst_cnt + 8'd1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_wr_en) begin
                        if (MAX_BURST == 1) begin
                            rr_ptr <= next_id(winner);
                        end else begin
                            state     <= BURST;
                            owner     <= winner;
                            burst_cnt <= 8'd1;
                        end
                    end
                end
                BURST: begin
                    if (!req_valid[owner]) begin
                        state     <= IDLE;
                        rr_ptr    <= next_id(owner);
                        burst_cnt <= '0;
                    end else if (fifo_wr_en) begin
                        if (burst_next == 8'(MAX_BURST)) begin
                            state     <= IDLE;
                            rr_ptr    <= next_id(owner);
                            burst_cnt <= '0;
                        end else begin
                            burst_cnt <= burst_next;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef FIFO_WR_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_count  <= '0;
            stall_count <= '0;
        end else begin
            if (fifo_wr_en && beat_count != 16'hFFFF) begin
                beat_count <= beat_count + 16'd1;
            end
            if (stall && stall_count != 16'hFFFF) begin
                stall_count <= stall_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8, MAX_BURST=4).
// Statistics checks are compiled in when FIFO_WR_ARB_STATS_EN is defined.
`timescale 1ns/1ps

module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_data;
    logic        fifo_wr_ready;
    logic        grant_valid;
    logic [1:0]  grant_id;
`ifdef FIFO_WR_ARB_STATS_EN
    logic [15:0] beat_count;
    logic [15:0] stall_count;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ   (4),
        .DATA_WIDTH(8),
        .MAX_BURST (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data),
        .fifo_wr_ready(fifo_wr_ready),
        .grant_valid  (grant_valid),
`ifdef FIFO_WR_ARB_STATS_EN
        .beat_count   (beat_count),
        .stall_count  (stall_count),
`endif
        .grant_id     (grant_id)
    );

    // Observed output bundle: {grant_valid, grant_id, fifo_wr_en, req_ready}.
    logic [7:0] obs;
    assign obs = {grant_valid, grant_id, fifo_wr_en, req_ready};

    function automatic logic [7:0] ex(input logic gv, input logic [1:0] id,
                                      input logic en, input logic [3:0] rdy);
        return {gv, id, en, rdy};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        req_valid     = 4'b0000;
        fifo_wr_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            #1;
            checks++;
            if (obs !== 8'h00) begin
                errors++;
                $display("FAIL reset_idle[%0d]: got %h want %h", c, obs, 8'h00);
            end
            tick();
        end
        // rr_ptr still 0: with everyone requesting, id0 wins.
        req_valid = 4'b1111;
        #1;
        checks++;
        if (obs !== ex(1'b1, 2'd0, 1'b1, 4'b0001)) begin
            errors++;
            $display("FAIL reset_first_winner: got %h want %h", obs, ex(1'b1, 2'd0, 1'b1, 4'b0001));
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic [1:0] id;
        do_reset();
        req_valid = 4'b1111;
        for (int k = 0; k < 20; k++) begin
            id = 2'((k / 4) % 4);
            #1;
            checks++;
            if (obs !== ex(1'b1, id, 1'b1, 4'(1 << id))) begin
                errors++;
                $display("FAIL rr_beat[%0d]: got %h want %h", k, obs, ex(1'b1, id, 1'b1, 4'(1 << id)));
            end
            checks++;
            if (fifo_wr_data !== 8'hA0 + 8'(id)) begin
                errors++;
                $display("FAIL rr_data[%0d]: got %h want %h", k, fifo_wr_data, 8'hA0 + 8'(id));
            end
            tick();
        end
    endtask

    task automatic test_release();
        do_reset();
        req_valid = 4'b0100;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (obs !== ex(1'b1, 2'd2, 1'b1, 4'b0100)) begin
                errors++;
                $display("FAIL release_beat[%0d]: got %h want %h", k, obs, ex(1'b1, 2'd2, 1'b1, 4'b0100));
            end
            tick();
        end
        req_valid = 4'b1000;
        #1;
        checks++;
        if (obs !== 8'h00) begin
            errors++;
            $display("FAIL release_gap: got %h want %h", obs, 8'h00);
        end
        tick();
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (obs !== ex(1'b1, 2'd3, 1'b1, 4'b1000) || fifo_wr_data !== 8'hA3) begin
                errors++;
                $display("FAIL release_next[%0d]: got %h/%h want %h/%h", k, obs, fifo_wr_data,
                         ex(1'b1, 2'd3, 1'b1, 4'b1000), 8'hA3);
            end
            tick();
        end
    endtask

    task automatic test_stall();
        do_reset();
        req_valid = 4'b0010;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (obs !== ex(1'b1, 2'd1, 1'b1, 4'b0010)) begin
                errors++;
                $display("FAIL stall_pre[%0d]: got %h want %h", k, obs, ex(1'b1, 2'd1, 1'b1, 4'b0010));
            end
            tick();
        end
        req_valid     = 4'b1111;
        fifo_wr_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (obs !== ex(1'b1, 2'd1, 1'b0, 4'b0000)) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got %h want %h", k, obs, ex(1'b1, 2'd1, 1'b0, 4'b0000));
            end
            tick();
        end
        fifo_wr_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (obs !== ex(1'b1, 2'd1, 1'b1, 4'b0010)) begin
                errors++;
                $display("FAIL stall_resume[%0d]: got %h want %h", k, obs, ex(1'b1, 2'd1, 1'b1, 4'b0010));
            end
            tick();
        end
`ifdef FIFO_WR_ARB_STATS_EN
        checks++;
        if (beat_count !== 16'd4 || stall_count !== 16'd3) begin
            errors++;
            $display("FAIL stats_scenario: got beats=%0d stalls=%0d want beats=4 stalls=3",
                     beat_count, stall_count);
        end
`endif
        #1;
        checks++;
        if (obs !== ex(1'b1, 2'd2, 1'b1, 4'b0100)) begin
            errors++;
            $display("FAIL stall_rotate: got %h want %h", obs, ex(1'b1, 2'd2, 1'b1, 4'b0100));
        end
        tick();
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        req_valid = 4'b1000;
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 8'h00) begin
            errors++;
            $display("FAIL midrst_immediate: got %h want %h", obs, 8'h00);
        end
        tick();
        checks++;
        if (obs !== 8'h00) begin
            errors++;
            $display("FAIL midrst_held: got %h want %h", obs, 8'h00);
        end
`ifdef FIFO_WR_ARB_STATS_EN
        checks++;
        if (beat_count !== 16'd0 || stall_count !== 16'd0) begin
            errors++;
            $display("FAIL stats_reset: got beats=%0d stalls=%0d want 0/0", beat_count, stall_count);
        end
`endif
        rst_n     = 1'b1;
        req_valid = 4'b1001;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++;
            if (obs !== ex(1'b1, 2'd0, 1'b1, 4'b0001) || fifo_wr_data !== 8'hA0) begin
                errors++;
                $display("FAIL midrst_after[%0d]: got %h/%h want %h/%h", k, obs, fifo_wr_data,
                         ex(1'b1, 2'd0, 1'b1, 4'b0001), 8'hA0);
            end
            tick();
        end
    endtask

`ifdef FIFO_WR_ARB_STATS_EN
    task automatic test_stats_saturate();
        test_stall();
        req_valid     = 4'b1111;
        fifo_wr_ready = 1'b1;
        repeat (70000) tick();
        checks++;
        if (beat_count !== 16'hFFFF || stall_count !== 16'd3) begin
            errors++;
            $display("FAIL stats_saturate: got beats=%h stalls=%0d want beats=ffff stalls=3",
                     beat_count, stall_count);
        end
    endtask
`endif

    initial begin
        rst_n         = 1'b0;
        req_valid     = 4'b0000;
        fifo_wr_ready = 1'b1;
        req_data      = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        test_reset();
        test_round_robin();
        test_release();
        test_stall();
        test_reset_mid_burst();
`ifdef FIFO_WR_ARB_STATS_EN
        test_stats_saturate();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
